// File: rtl/pcap_word_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcap_word_packer_if
//  Description : Bundles the byte-side and beat-side signals of the pcap word
//                packer.
//                slave  - the packer: consumes bytes, produces beats.
//                master - the environment: byte source plus beat sink.
//  Signals     : in_valid/in_data/in_pktcount/in_flush - byte source side
//                pause                                 - backpressure to source
//                out_valid/out_ready/out_data/out_keep/
//                out_sop/out_eop                       - packed beat stream
//  Revision    : 1.0 - initial release
// ============================================================================
interface pcap_word_packer_if #(
    parameter int BYTES = 4
) ();
    logic                 in_valid;
    logic [7:0]           in_data;
    logic [7:0]           in_pktcount;
    logic                 in_flush;
    logic                 pause;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*BYTES-1:0]   out_data;
    logic [BYTES-1:0]     out_keep;
    logic                 out_sop;
    logic                 out_eop;

    modport slave (
        input  in_valid, in_data, in_pktcount, in_flush, out_ready,
        output pause, out_valid, out_data, out_keep, out_sop, out_eop
    );

    modport master (
        output in_valid, in_data, in_pktcount, in_flush, out_ready,
        input  pause, out_valid, out_data, out_keep, out_sop, out_eop
    );
endinterface
`default_nettype wire

// File: rtl/pcap_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : pcap_word_packer
//  Description : Packs a pcap byte stream into BYTES-wide beats with keep,
//                sop and eop. A beat is closed by the next accepted byte
//                (full accumulator or packet change) or by in_flush, and
//                appears on the output register one cycle later.
//  Ports       : CLOCK - single clock, rising edge
//                RESET - asynchronous active-high reset
//                bus   - pcap_word_packer_if.slave (byte in, beat out)
//                stat_pkts/stat_bytes - only with PCAP_PACKER_STATS_EN
//  Options     : `define PCAP_PACKER_STATS_EN adds emitted packet/byte counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pcap_word_packer #(
    parameter int BYTES = 4
) (
    input  wire logic           CLOCK,
    input  wire logic           RESET,
    pcap_word_packer_if.slave   bus
`ifdef PCAP_PACKER_STATS_EN
    ,
    output logic [15:0]         stat_pkts,
    output logic [31:0]         stat_bytes
`endif
);
    localparam int                 c_cnt_w = $clog2(BYTES + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(BYTES);

    logic [8*BYTES-1:0] r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_acc_sop;   // accumulator holds first beat of packet
    logic               r_pkt_open;
    logic [7:0]         r_pkt_id;

    logic               w_pause;
    logic               w_accept;
    logic               w_new_pkt;
    logic               w_acc_busy;
    logic               w_emit_byte;
    logic               w_emit_flush;
    logic               w_load;
    logic [8*BYTES-1:0] w_acc_ins;
    logic [BYTES-1:0]   w_keep;

    assign w_pause      = bus.out_valid & ~bus.out_ready;
    assign bus.pause    = w_pause;
    assign w_accept     = bus.in_valid & ~w_pause;
    // Inequality only: a 255->0 pktcount wrap still opens a new packet.
    assign w_new_pkt    = ~r_pkt_open | (bus.in_pktcount != r_pkt_id);
    assign w_acc_busy   = (r_cnt != '0);
    // A full accumulator waits for the next byte so its eop is known.
    assign w_emit_byte  = w_accept & w_acc_busy & ((r_cnt == c_full) | w_new_pkt);
    assign w_emit_flush = bus.in_flush & ~w_accept & w_acc_busy & ~w_pause;
    assign w_load       = w_emit_byte | w_emit_flush;

    // Byte inserted at the next free lane, and keep mask of current contents.
    always_comb begin
        w_acc_ins = r_acc;
        w_keep    = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (c_cnt_w'(i) == r_cnt) w_acc_ins[8*i +: 8] = bus.in_data;
            if (c_cnt_w'(i) <  r_cnt) w_keep[i] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_keep  <= '0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_acc_sop     <= 1'b0;
            r_pkt_open    <= 1'b0;
            r_pkt_id      <= '0;
        end else begin
            // Loading only happens when pause is low, so the output
            // register is either empty or being consumed this edge.
            if (w_load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= r_acc;
                bus.out_keep  <= w_keep;
                bus.out_sop   <= r_acc_sop;
                bus.out_eop   <= w_emit_flush | w_new_pkt;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_emit_byte) begin
                    r_acc     <= (8*BYTES)'(bus.in_data);
                    r_cnt     <= c_cnt_w'(1);
                    r_acc_sop <= w_new_pkt;
                end else begin
                    r_acc <= w_acc_ins;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (!w_acc_busy) r_acc_sop <= 1'b1;
                end
                r_pkt_id   <= bus.in_pktcount;
                r_pkt_open <= 1'b1;
            end else if (w_emit_flush) begin
                r_acc      <= '0;
                r_cnt      <= '0;
                r_acc_sop  <= 1'b0;
                r_pkt_open <= 1'b0;
            end
        end
    end

`ifdef PCAP_PACKER_STATS_EN
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else if (w_load) begin
            if (w_emit_flush | w_new_pkt) stat_pkts <= stat_pkts + 16'd1;
            stat_bytes <= stat_bytes + 32'(r_cnt);
        end
    end
`endif
endmodule
`default_nettype wire
